// File: rtl/core_sequencer_if.sv
// Control/handshake bundle between the core sequencer and the riscv32i datapath.
// The master modport is the sequencer side; the slave modport is the datapath/memory side.
interface core_sequencer_if #(
    parameter int unsigned N_param = 32
);
    logic               en_i;
    logic               imem_ready_i;
    logic               dmem_ready_i;
    logic               illegal_i;
    logic               is_load_i;
    logic               is_store_i;
    logic               writes_rd_i;
    logic [4:0]         rd_i;
    logic               take_pc_i;
    logic [N_param-1:0] target_i;

    logic [N_param-1:0] pc_o;
    logic               imem_req_o;
    logic               ir_we_o;
    logic               dec_en_o;
    logic               alu_en_o;
    logic               dmem_req_o;
    logic               dmem_we_o;
    logic               reg_we_o;
    logic               trap_o;
    logic [2:0]         trap_cause_o;
    logic [31:0]        instret_o;
    logic [2:0]         state_o;

    modport master (
        input  en_i, imem_ready_i, dmem_ready_i, illegal_i, is_load_i, is_store_i,
               writes_rd_i, rd_i, take_pc_i, target_i,
        output pc_o, imem_req_o, ir_we_o, dec_en_o, alu_en_o, dmem_req_o, dmem_we_o,
               reg_we_o, trap_o, trap_cause_o, instret_o, state_o
    );

    modport slave (
        output en_i, imem_ready_i, dmem_ready_i, illegal_i, is_load_i, is_store_i,
               writes_rd_i, rd_i, take_pc_i, target_i,
        input  pc_o, imem_req_o, ir_we_o, dec_en_o, alu_en_o, dmem_req_o, dmem_we_o,
               reg_we_o, trap_o, trap_cause_o, instret_o, state_o
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the riscv32i core: owns the PC and steps each instruction
// through fetch, decode, execute, optional memory access and writeback, trapping on faults.
module core_sequencer #(
    parameter int unsigned        N_param     = 32,
    parameter logic [N_param-1:0] RESET_PC    = '0,
    parameter int unsigned        MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    core_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StTrap      = 3'd7
    } state_e;

    localparam int unsigned      CntW     = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT - 1);

    state_e             state_q;
    logic [N_param-1:0] pc_q;
    logic [31:0]        instret_q;
    logic [2:0]         cause_q;
    logic [CntW-1:0]    cnt_q;
    logic               store_q;
    logic               misaligned;

    assign misaligned = bus.take_pc_i && (bus.target_i[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            cause_q   <= 3'd0;
            cnt_q     <= '0;
            store_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.en_i) state_q <= StFetch;
                end
                StFetch: begin
                    // A ready arriving on the limit cycle is accepted, so test it first.
                    if (bus.imem_ready_i) begin
                        cnt_q   <= '0;
                        state_q <= StDecode;
                    end else if (cnt_q == CntLimit) begin
                        cause_q <= 3'd2;
                        state_q <= StTrap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDecode: begin
                    if (bus.illegal_i) begin
                        cause_q <= 3'd1;
                        state_q <= StTrap;
                    end else begin
                        state_q <= StExecute;
                    end
                end
                StExecute: begin
                    store_q <= bus.is_store_i;
                    cnt_q   <= '0;
                    state_q <= (bus.is_load_i || bus.is_store_i) ? StMem : StWriteback;
                end
                StMem: begin
                    if (bus.dmem_ready_i) begin
                        cnt_q   <= '0;
                        state_q <= StWriteback;
                    end else if (cnt_q == CntLimit) begin
                        cause_q <= 3'd3;
                        state_q <= StTrap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWriteback: begin
                    if (misaligned) begin
                        cause_q <= 3'd4;
                        state_q <= StTrap;
                    end else begin
                        pc_q      <= bus.take_pc_i ? bus.target_i : pc_q + N_param'(4);
                        instret_q <= instret_q + 32'd1;
                        state_q   <= bus.en_i ? StFetch : StIdle;
                    end
                end
                StTrap: ;
                default: state_q <= StTrap;
            endcase
        end
    end

    always_comb begin
        bus.imem_req_o = 1'b0;
        bus.ir_we_o    = 1'b0;
        bus.dec_en_o   = 1'b0;
        bus.alu_en_o   = 1'b0;
        bus.dmem_req_o = 1'b0;
        bus.dmem_we_o  = 1'b0;
        bus.reg_we_o   = 1'b0;
        bus.trap_o     = 1'b0;
        case (state_q)
            StFetch: begin
                bus.imem_req_o = 1'b1;
                bus.ir_we_o    = bus.imem_ready_i;
            end
            StDecode:  bus.dec_en_o = 1'b1;
            StExecute: bus.alu_en_o = 1'b1;
            StMem: begin
                bus.dmem_req_o = 1'b1;
                bus.dmem_we_o  = store_q;
            end
            // x0 is hardwired zero, so a write to it is dropped here.
            StWriteback: bus.reg_we_o = bus.writes_rd_i && (bus.rd_i != 5'd0) && !misaligned;
            StTrap:      bus.trap_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_o         = pc_q;
    assign bus.instret_o    = instret_q;
    assign bus.trap_cause_o = cause_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: walks instructions cycle by cycle and checks
// each retirement against a scoreboard of expected outcomes queued at issue time.
module tb_core_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;

    typedef struct {
        logic        reg_we;
        logic [31:0] pc;
        logic [31:0] instret;
        logic [2:0]  state;
        logic [2:0]  cause;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    core_sequencer_if #(.N_param(32)) bus ();

    core_sequencer #(
        .N_param    (32),
        .RESET_PC   (32'h0000_0000),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // {imem_req, ir_we, dec_en, alu_en, dmem_req, dmem_we, reg_we, trap}
    function automatic logic [7:0] strobes();
        return {bus.imem_req_o, bus.ir_we_o, bus.dec_en_o, bus.alu_en_o,
                bus.dmem_req_o, bus.dmem_we_o, bus.reg_we_o, bus.trap_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_ready_i = 1'b0;
        bus.dmem_ready_i = 1'b0;
        bus.illegal_i    = 1'b0;
        bus.is_load_i    = 1'b0;
        bus.is_store_i   = 1'b0;
        bus.writes_rd_i  = 1'b0;
        bus.rd_i         = 5'd0;
        bus.take_pc_i    = 1'b0;
        bus.target_i     = 32'd0;
    endtask

    task automatic do_reset();
        bus.en_i = 1'b0;
        clear_inputs();
        reset = 1'b1;
        #2;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_instret", bus.instret_o, 32'd0);
        chk("rst_cause", 32'(bus.trap_cause_o), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'h00);
        tick();
        reset = 1'b0;
        m_pc      = 32'h0;
        m_instret = 32'd0;
    endtask

    task automatic start();
        bus.en_i = 1'b1;
        #1;
        chk("idle_state", 32'(bus.state_o), 32'd0);
        chk("idle_strobes", 32'(strobes()), 32'h00);
        tick();
    endtask

    // Precondition: DUT in FETCH, 1 time unit after a rising edge.
    task automatic run_instr(input int iw, input bit ill, input bit ld, input bit st,
                             input bit wr, input logic [4:0] rd, input bit tk,
                             input logic [31:0] tgt, input int dw, input bit en_next);
        exp_t        e;
        logic [31:0] cur_pc;
        bit          mis;
        cur_pc   = m_pc;
        mis      = tk && (tgt[1:0] != 2'b00);
        e.reg_we = !ill && !mis && wr && (rd != 5'd0);
        if (ill || mis) begin
            e.pc      = m_pc;
            e.instret = m_instret;
            e.state   = 3'd7;
            e.cause   = ill ? 3'd1 : 3'd4;
        end else begin
            m_pc      = tk ? tgt : m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
            e.pc      = m_pc;
            e.instret = m_instret;
            e.state   = en_next ? 3'd1 : 3'd0;
            e.cause   = 3'd0;
        end
        sb.push_back(e);

        for (int w = 0; w <= iw; w++) begin
            bus.imem_ready_i = (w == iw);
            #1;
            chk("fetch_state", 32'(bus.state_o), 32'd1);
            chk("fetch_strobes", 32'(strobes()), (w == iw) ? 32'hC0 : 32'h80);
            chk("fetch_pc", bus.pc_o, cur_pc);
            tick();
        end
        bus.imem_ready_i = 1'b0;

        bus.illegal_i = ill;
        #1;
        chk("decode_state", 32'(bus.state_o), 32'd2);
        chk("decode_strobes", 32'(strobes()), 32'h20);
        tick();
        bus.illegal_i = 1'b0;
        if (ill) begin
            e = sb.pop_front();
            chk("illegal_state", 32'(bus.state_o), 32'(e.state));
            chk("illegal_cause", 32'(bus.trap_cause_o), 32'(e.cause));
            chk("illegal_pc", bus.pc_o, e.pc);
            chk("illegal_instret", bus.instret_o, e.instret);
            return;
        end

        bus.is_load_i  = ld;
        bus.is_store_i = st;
        bus.en_i       = en_next;
        #1;
        chk("exec_state", 32'(bus.state_o), 32'd3);
        chk("exec_strobes", 32'(strobes()), 32'h10);
        tick();
        bus.is_load_i  = 1'b0;
        bus.is_store_i = 1'b0;

        if (ld || st) begin
            for (int w = 0; w <= dw; w++) begin
                bus.dmem_ready_i = (w == dw);
                #1;
                chk("mem_state", 32'(bus.state_o), 32'd4);
                chk("mem_strobes", 32'(strobes()), st ? 32'h0C : 32'h08);
                tick();
            end
            bus.dmem_ready_i = 1'b0;
        end

        bus.writes_rd_i = wr;
        bus.rd_i        = rd;
        bus.take_pc_i   = tk;
        bus.target_i    = tgt;
        #1;
        e = sb.pop_front();
        chk("wb_state", 32'(bus.state_o), 32'd5);
        chk("wb_strobes", 32'(strobes()), e.reg_we ? 32'h02 : 32'h00);
        tick();
        clear_inputs();
        chk("next_state", 32'(bus.state_o), 32'(e.state));
        chk("next_pc", bus.pc_o, e.pc);
        chk("next_instret", bus.instret_o, e.instret);
        chk("next_cause", 32'(bus.trap_cause_o), 32'(e.cause));
    endtask

    // ready_at: 1-based FETCH cycle on which ready arrives, 0 for never.
    task automatic fetch_timeout(input int ready_at);
        for (int c = 1; c <= 16; c++) begin
            bus.imem_ready_i = (c == ready_at);
            #1;
            chk("to_fetch_state", 32'(bus.state_o), 32'd1);
            tick();
        end
        bus.imem_ready_i = 1'b0;
        if (ready_at == 0) begin
            chk("to_trap_state", 32'(bus.state_o), 32'd7);
            chk("to_trap_cause", 32'(bus.trap_cause_o), 32'd2);
            chk("to_trap_pc", bus.pc_o, m_pc);
        end else begin
            chk("to_late_ready_state", 32'(bus.state_o), 32'd2);
        end
    endtask

    task automatic hold_trap(input int n, input logic [2:0] cause, input logic [31:0] pc);
        bus.en_i         = 1'b1;
        bus.imem_ready_i = 1'b1;
        bus.dmem_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("trap_strobes", 32'(strobes()), 32'h01);
            chk("trap_cause_hold", 32'(bus.trap_cause_o), 32'(cause));
            chk("trap_pc_hold", bus.pc_o, pc);
        end
        clear_inputs();
    endtask

    initial begin
        reset  = 1'b1;
        bus.en_i = 1'b0;
        clear_inputs();
        do_reset();
        start();

        // Three back-to-back ALU ops writing x5
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 1, 5'd5, 0, 32'h0, 0, 1);
        chk("alu_x3_pc", bus.pc_o, 32'h0000_000C);
        chk("alu_x3_instret", bus.instret_o, 32'd3);

        // Store with three dmem wait cycles
        run_instr(0, 0, 0, 1, 0, 5'd0, 0, 32'h0, 3, 1);

        // Taken branch at 0x10, then wrap through 0xFFFF_FFFC with imem waits
        run_instr(0, 0, 0, 0, 0, 5'd0, 1, 32'h0000_0040, 0, 1);
        run_instr(0, 0, 0, 0, 1, 5'd3, 1, 32'hFFFF_FFFC, 0, 1);
        run_instr(2, 0, 0, 0, 1, 5'd3, 0, 32'h0, 0, 1);
        chk("wrap_pc", bus.pc_o, 32'h0);

        // Misaligned target traps with no retire
        run_instr(0, 0, 0, 0, 1, 5'd7, 1, 32'h0000_0042, 0, 1);
        hold_trap(3, 3'd4, 32'h0);

        // Illegal instruction, trap held 20 cycles, then reset clears it
        do_reset();
        start();
        run_instr(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 0, 1);
        run_instr(0, 1, 0, 0, 0, 5'd0, 0, 32'h0, 0, 1);
        hold_trap(20, 3'd1, 32'h4);
        do_reset();
        chk("post_trap_reset_trap", 32'(bus.trap_o), 32'd0);

        // imem never ready: trap after 16 FETCH cycles
        start();
        fetch_timeout(0);
        do_reset();
        // ready on the 16th cycle wins
        start();
        fetch_timeout(16);

        // Reset mid-instruction during MEM: no retire
        do_reset();
        start();
        bus.imem_ready_i = 1'b1;
        tick();
        bus.imem_ready_i = 1'b0;
        tick();
        bus.is_load_i = 1'b1;
        tick();
        bus.is_load_i = 1'b0;
        chk("mid_mem_state", 32'(bus.state_o), 32'd4);
        do_reset();

        // Load to x0, en dropped during EXECUTE: retire then park in IDLE
        start();
        run_instr(0, 0, 1, 0, 1, 5'd0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("parked_state", 32'(bus.state_o), 32'd0);
            chk("parked_pc", bus.pc_o, 32'h4);
        end
        bus.en_i = 1'b1;
        tick();
        chk("resume_state", 32'(bus.state_o), 32'd1);
        chk("resume_pc", bus.pc_o, 32'h4);
        run_instr(1, 0, 0, 0, 1, 5'd1, 0, 32'h0, 0, 1);
        chk("resume_instret", bus.instret_o, 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the riscv32i core. It owns the PC and sequences instruction fetch, decode enable, execute, data-memory access and register-file writeback, one instruction at a time. It drives the instruction-memory request, the decode i_en, the reg_file we_pi and the data-memory request. It also traps on illegal instructions, misaligned jump/branch targets and memory timeouts.

Parameters:
N_param, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 16, max wait cycles for imem/dmem ready before trap (>=2)

Ports:
clk  in  1  core clock, rising-edge
reset  in  1  asynchronous, active-high reset
en_i  in  1  run enable; sampled in IDLE and at end of WRITEBACK
imem_ready_i  in  1  instruction word valid this cycle
dmem_ready_i  in  1  data access complete this cycle
illegal_i  in  1  decode flag: unrecognised instruction (all Single_Instruction bits 0)
is_load_i  in  1  decode flag: load
is_store_i  in  1  decode flag: store
writes_rd_i  in  1  decode flag: instruction writes rd
rd_i  in  5  destination register from decode
take_pc_i  in  1  execute result: branch taken or jump
target_i  in  N_param  execute result: next-PC target
pc_o  out  N_param  current instruction PC
imem_req_o  out  1  fetch request
ir_we_o  out  1  latch instruction register
dec_en_o  out  1  decode enable (drives decode i_en)
alu_en_o  out  1  execute enable
dmem_req_o  out  1  data-memory request
dmem_we_o  out  1  data-memory write (valid with dmem_req_o)
reg_we_o  out  1  register-file write enable (drives we_pi)
trap_o  out  1  core halted in TRAP
trap_cause_o  out  3  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout, 4 misaligned target
instret_o  out  32  retired-instruction counter
state_o  out  3  FSM state (debug)

Behaviour:
- Reset (async): state IDLE, pc_o=RESET_PC, instret_o=0, trap_cause_o=0, timeout counter=0, latched store flag=0. All strobes are 0. Reset asserted mid-instruction aborts it immediately with no write or retire.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=7. Strobes are combinational decodes of state/inputs. state_o=state.
- IDLE: no strobes. en_i=1 -> FETCH.
- FETCH: imem_req_o=1.
  - imem_ready_i=1: ir_we_o=1 in the same cycle, go to DECODE, clear counter.
  - Otherwise the counter increments. If the counter reaches MEM_TIMEOUT-1 while still not ready, go to TRAP with cause 2.
  - Ready arriving in the same cycle as the limit wins (no trap).
- DECODE (1 cycle): dec_en_o=1. illegal_i=1 -> TRAP cause 1. Otherwise -> EXECUTE.
- EXECUTE (1 cycle): alu_en_o=1. Latch is_store_i. is_load_i|is_store_i -> MEM. Otherwise -> WRITEBACK.
- MEM: dmem_req_o=1 and dmem_we_o=latched store flag, both held until ready.
  - dmem_ready_i=1 -> WRITEBACK.
  - Timeout uses the same rule as FETCH, trapping with cause 3.
- WRITEBACK (1 cycle):
  - If take_pc_i=1 and target_i[1:0]!=0: go to TRAP cause 4. No reg write, no retire, PC unchanged.
  - Otherwise reg_we_o = writes_rd_i & (rd_i!=0). The x0 write is suppressed.
  - PC update: pc_o <= take_pc_i ? target_i : pc_o+4 (mod 2^N_param, so 32'hFFFF_FFFC wraps to 0).
  - instret_o += 1, wrapping at 2^32.
  - Next state: FETCH if en_i=1, else IDLE.
- en_i deasserted mid-instruction: the current instruction completes, then the FSM parks in IDLE.
- TRAP: trap_o=1, all other strobes 0, pc_o and trap_cause_o frozen at the faulting instruction. Exit only by reset.
- Minimum latency per instruction: 4 cycles (0-wait ALU op), 5 cycles (0-wait load/store). Each imem/dmem wait cycle adds 1.

Test Plan:
1. Reset with en_i=1, imem_ready_i=1 always, ALU op (writes_rd_i=1, rd_i=5) x3 -> states 1,2,3,5 repeat; reg_we_o pulses every 4th cycle; pc_o 0->4->8->C; instret_o=3.
2. Store with dmem_ready_i delayed 3 cycles -> MEM held 4 cycles with dmem_req_o=1, dmem_we_o=1; then WRITEBACK, reg_we_o=0, pc_o+=4.
3. Branch at pc 0x10, take_pc_i=1, target_i=0x40 -> next FETCH pc_o=0x40. Same test with target_i=0x42 -> TRAP, trap_cause_o=4, pc_o=0x10, instret_o unchanged.
4. imem_ready_i held 0, MEM_TIMEOUT=16 -> TRAP after 16 FETCH cycles, cause 2. Rerun with ready arriving on the 16th cycle -> no trap.
5. illegal_i=1 in DECODE -> TRAP cause 1, trap_o=1 persists 20 cycles. Assert reset -> IDLE, pc_o=RESET_PC, trap_o=0.
6. Load with writes_rd_i=1, rd_i=0 -> reg_we_o stays 0. Drop en_i during EXECUTE -> instruction retires, FSM enters IDLE. Raise en_i -> FETCH resumes at pc_o+4.
